// File: rtl/uart_tx_framer.sv
// ----------------------------------------------------------------------------
// uart_tx_framer
//
// Buffered UART transmit framer. Words arrive on a valid/ready handshake, wait
// in a small circular FIFO and are sent on the serial line as one start bit
// (0), DATA_W data bits MSB first and STOP_BITS stop bits (1). Each bit lasts
// CLKS_PER_BIT clocks. The line idles high, and back-to-back frames have no
// idle gap between them.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   in_valid    in_data holds a word to send
//   in_data     word to transmit (DATA_W bits)
//   in_ready    FIFO can accept a word (combinational from the registered count)
//   tx          serial line, registered, idle high
//   busy        registered, high whenever the serialiser is not idle
//   fifo_count  number of words held in the FIFO, registered
// ----------------------------------------------------------------------------
module uart_tx_framer #(
    parameter int DATA_W       = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [DATA_W-1:0]                 in_data,
    output logic                              in_ready,
    output logic                              tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // A one-clock bit still needs a 1-bit counter so the compare stays legal.
    localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    // DATA_W >= 2 guarantees at least one bit; STOP_BITS-1 (0 or 1) always fits.
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] COUNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] COUNT_ZERO = CNT_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CLK_W-1:0] CLK_LAST   = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] CLK_ONE    = CLK_W'(1);
    localparam logic [CLK_W-1:0] CLK_ZERO   = CLK_W'(0);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_ZERO   = BIT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic [DATA_W-1:0]      sh_q, sh_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CLK_W-1:0]       clk_cnt_q, clk_cnt_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       fifo_count_q, fifo_count_d;
    logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]      mem_d [FIFO_DEPTH];

    logic                   in_ready_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   bit_end_s;
    logic                   fifo_nonempty_s;

    // Serialiser next-state logic: decides pops, line level and shift contents.
    always_comb begin
        fifo_nonempty_s = (fifo_count_q != COUNT_ZERO);
        bit_end_s       = (clk_cnt_q == CLK_LAST);

        state_d   = state_q;
        tx_d      = tx_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        clk_cnt_d = bit_end_s ? CLK_ZERO : (clk_cnt_q + CLK_ONE);
        pop_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d      = 1'b1;
                clk_cnt_d = CLK_ZERO;
                bit_cnt_d = BIT_ZERO;
                if (fifo_nonempty_s) begin
                    pop_s   = 1'b1;
                    sh_d    = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    tx_d      = sh_q[DATA_W-1];
                    sh_d      = {sh_q[DATA_W-2:0], 1'b0};
                    bit_cnt_d = BIT_ZERO;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        tx_d      = 1'b1;
                        bit_cnt_d = BIT_ZERO;
                        state_d   = ST_STOP;
                    end else begin
                        tx_d      = sh_q[DATA_W-1];
                        sh_d      = {sh_q[DATA_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = BIT_ZERO;
                        if (fifo_nonempty_s) begin
                            // Next frame starts straight after the last stop bit.
                            pop_s   = 1'b1;
                            sh_d    = mem_q[rd_ptr_q];
                            tx_d    = 1'b0;
                            state_d = ST_START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                tx_d      = 1'b1;
                clk_cnt_d = CLK_ZERO;
                bit_cnt_d = BIT_ZERO;
                state_d   = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // FIFO next-state logic: handshake, pointers, occupancy and storage.
    always_comb begin
        // Ready depends only on the registered count, so a push never lands on
        // a full FIFO even when a pop happens on the same edge.
        in_ready_s = (fifo_count_q < COUNT_FULL);
        push_s     = in_valid && in_ready_s;

        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = in_data;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end

        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   fifo_count_d = fifo_count_q + COUNT_ONE;
            2'b01:   fifo_count_d = fifo_count_q - COUNT_ONE;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // State register; reset abandons any frame in flight and empties the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            sh_q         <= '0;
            bit_cnt_q    <= BIT_ZERO;
            clk_cnt_q    <= CLK_ZERO;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fifo_count_q <= COUNT_ZERO;
            mem_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            sh_q         <= sh_d;
            bit_cnt_q    <= bit_cnt_d;
            clk_cnt_q    <= clk_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fifo_count_q <= fifo_count_d;
            mem_q        <= mem_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = fifo_count_q;

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Buffered UART transmit framer. It sits directly upstream of the serial receiver and drives its `rx` line. Parallel words enter through a valid/ready handshake into a small FIFO. Each word is serialised as one start bit (0), DATA_W data bits MSB first, and STOP_BITS stop bits (1), each bit held for CLKS_PER_BIT clocks. The line idles high.

## Interface
- DATA_W, 5, data bits per frame (≥2)
- FIFO_DEPTH, 4, word FIFO entries (power of 2, ≥2)
- CLKS_PER_BIT, 1, clocks per serial bit (≥1)
- STOP_BITS, 1, stop bits per frame (1 or 2)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_data holds a word to send
- in_data  in  DATA_W  word to transmit
- in_ready  out  1  FIFO can accept a word; high when fifo_count < FIFO_DEPTH (combinational from count)
- tx  out  1  serial line, registered, idle high
- busy  out  1  registered; high whenever the FSM is not in IDLE
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words stored in the FIFO, registered

## Operation
- Push: a word is written when in_valid && in_ready at a rising edge. Words offered while in_ready=0 are not written. The source holds them.
- FIFO:
  - circular, with rd/wr pointers of width $clog2(FIFO_DEPTH) that wrap modulo FIFO_DEPTH
  - push+pop in the same edge leaves fifo_count unchanged
  - no push is possible when full, so there is no overflow
  - no pop is possible when empty
- FSM states: IDLE, START, DATA, STOP. bit_cnt counts data/stop bits. clk_cnt counts 0..CLKS_PER_BIT-1 within each bit.
- IDLE:
  - tx=1
  - if fifo_count>0: pop the head into shift register sh, set tx<=0, clk_cnt<=0, and go to START
- START: when clk_cnt==CLKS_PER_BIT-1, set tx<=sh[DATA_W-1], shift sh left, bit_cnt<=0, and go to DATA.
- DATA:
  - at the end of each bit, if bit_cnt==DATA_W-1, set tx<=1, bit_cnt<=0 and go to STOP
  - otherwise set tx<=next MSB and bit_cnt++
- STOP: at the end of each stop bit, when bit_cnt==STOP_BITS-1:
  - if fifo_count>0: pop, tx<=0, go to START (back-to-back, no idle gap)
  - else: go to IDLE with tx staying 1
- Pop happens only on the edge that enters START. FIFO contents never change mid-frame except through pushes.
- Reset (async, any state, including mid-frame):
  - tx=1, busy=0, fifo_count=0, in_ready=1
  - pointers=0, state=IDLE, all counters=0
  - partially sent words and queued words are discarded

## Timing
- Push latency:
  - word accepted at edge N into an empty FIFO while IDLE
  - fifo_count=1 after N
  - tx falls and busy rises at edge N+1, and fifo_count returns to 0 at N+1
- Frame length is (1+DATA_W+STOP_BITS)·CLKS_PER_BIT cycles; the default is 7.
- Bit k of a frame (k=0 is start) occupies cycles [N+1+k·CLKS_PER_BIT, N+1+(k+1)·CLKS_PER_BIT).
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- busy falls on the edge that returns to IDLE. tx is already 1 at that point.
- in_ready reflects count after the previous edge; it is low for the whole cycle in which fifo_count==FIFO_DEPTH.
- A push on the same edge as a pop from a full FIFO is not accepted. This is conservative: in_ready is based on the registered count.

## Test plan
- Reset: hold rst=0 with toggling inputs → tx=1, busy=0, fifo_count=0, in_ready=1; then release and idle for 20 cycles → tx stays 1, busy=0.
- Single word, defaults: push 5'b10110 at edge N → tx=0,1,0,1,1,0,1 on cycles N+1..N+7; tx=1 and busy=0 from N+8 onward; fifo_count returns to 0 at N+1.
- Back-to-back: push 5'b00001, 5'b11111, 5'b01010 on consecutive edges → 21 contiguous frame cycles; tx=0 exactly at offsets 0, 7, 14; data matches MSB-first order; no idle cycle between frames.
- Full FIFO, CLKS_PER_BIT=4: in_valid high continuously with 8 distinct words →
  - fifo_count never exceeds 4
  - in_ready is low while count==4
  - all 8 frames are emitted in push order with no loss or duplication
- Slow baud, CLKS_PER_BIT=3, STOP_BITS=2: push 5'b11000 → each bit is held exactly 3 cycles; the frame is 24 cycles; the final 6 cycles are high.
- Reset mid-frame: assert rst during the third data bit with 2 words queued →
  - tx=1 immediately, without waiting for clk
  - fifo_count=0, busy=0
  - after release, no frame is sent until a new push; the new push produces a correct frame at N+1
